// File: rtl/vga_tile_renderer_pkg.sv
// Shared colour constants, default board geometry and pipeline types for the tile renderer.
package vga_tile_renderer_pkg;

  typedef logic [2:0] rgb_t;

  localparam rgb_t BLACK = 3'b000;
  localparam rgb_t BLUE  = 3'b001;
  localparam rgb_t WHITE = 3'b111;

  localparam int unsigned DEF_COLS     = 6;
  localparam int unsigned DEF_ROWS     = 10;
  localparam int unsigned DEF_TILE_LG2 = 5;
  localparam int unsigned DEF_H_ORIGIN = 200;
  localparam int unsigned DEF_V_ORIGIN = 80;
  localparam int unsigned DEF_H_TOTAL  = 800;

  // Per-pixel decisions made in stage0 and carried alongside the tile RAM read.
  typedef struct packed {
    logic in_board;
    logic cursor;
    logic grid;
  } pix_attr_t;

endpackage

// File: rtl/vga_tile_ram.sv
// Tile colour store: synchronous write, registered read returning old data on a same-address write.
module vga_tile_ram #(
  parameter int unsigned DEPTH  = 60,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 3
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vga_tile_renderer.sv
// Tile board / grid / cursor pixel source with 2-cycle lookahead aligned to the VGA counters.
// Define CURSOR_BLINK_EN to blink the cursor box every BLINK_FRAMES frames.
module vga_tile_renderer
  import vga_tile_renderer_pkg::*;
#(
  parameter int unsigned COLS     = DEF_COLS,
  parameter int unsigned ROWS     = DEF_ROWS,
  parameter int unsigned TILE_LG2 = DEF_TILE_LG2,
  parameter int unsigned H_ORIGIN = DEF_H_ORIGIN,
  parameter int unsigned V_ORIGIN = DEF_V_ORIGIN,
  parameter int unsigned H_TOTAL  = DEF_H_TOTAL
`ifdef CURSOR_BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES = 15
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hcnt,
  input  logic [9:0] vcnt,
  input  logic [3:0] xk,
  input  logic [3:0] yk,
  input  logic       wr_en,
  input  logic [3:0] wr_x,
  input  logic [3:0] wr_y,
  input  logic [2:0] wr_color,
  output logic [2:0] rgb,
  output logic       frame_start
);

  localparam int unsigned Tiles = COLS * ROWS;
  localparam int unsigned AddrW = $clog2(Tiles);
  localparam int unsigned Tile  = 1 << TILE_LG2;

  localparam logic [10:0] XLo  = 11'(H_ORIGIN);
  localparam logic [10:0] XHi  = 11'(H_ORIGIN + (COLS << TILE_LG2));
  localparam logic [10:0] XEnd = 11'(H_TOTAL);
  localparam logic [9:0]  YLo  = 10'(V_ORIGIN);
  localparam logic [9:0]  YHi  = 10'(V_ORIGIN + (ROWS << TILE_LG2));

  localparam logic [TILE_LG2-1:0] EdgeLo = TILE_LG2'(1);
  localparam logic [TILE_LG2-1:0] EdgeHi = TILE_LG2'(Tile - 2);

  logic [10:0]         px;
  logic [10:0]         rel_x;
  logic [9:0]          rel_y;
  logic [3:0]          tx;
  logic [3:0]          ty;
  logic [TILE_LG2-1:0] ox;
  logic [TILE_LG2-1:0] oy;
  logic                in_board;
  logic [AddrW-1:0]    rd_addr;
  logic [AddrW-1:0]    wr_addr;
  logic                wr_ok;
  logic                cursor_phase;
  logic [3:0]          cur_x_q;
  logic [3:0]          cur_y_q;
  pix_attr_t           attr_d;
  pix_attr_t           attr_q;
  rgb_t                tile_color;
  rgb_t                rgb_d;
  rgb_t                rgb_q;

  function automatic logic near_edge(input logic [TILE_LG2-1:0] o);
    return (o <= EdgeLo) || (o >= EdgeHi);
  endfunction

  assign frame_start = (hcnt == '0) && (vcnt == '0) && !rst;

  // Stage0: look two pixels ahead and classify the pixel.
  always_comb begin
    px       = {1'b0, hcnt} + 11'd2;
    rel_x    = px - XLo;
    rel_y    = vcnt - YLo;
    in_board = (px >= XLo) && (px < XHi) && (px < XEnd) && (vcnt >= YLo) && (vcnt < YHi);
    tx       = 4'(rel_x >> TILE_LG2);
    ty       = 4'(rel_y >> TILE_LG2);
    ox       = rel_x[TILE_LG2-1:0];
    oy       = rel_y[TILE_LG2-1:0];

    attr_d.in_board = in_board;
    attr_d.grid     = (ox == '0) || (oy == '0);
    attr_d.cursor   = cursor_phase && (tx == cur_x_q) && (ty == cur_y_q) &&
                      (near_edge(ox) || near_edge(oy));
    rd_addr         = in_board ? (AddrW'(ty) * AddrW'(COLS) + AddrW'(tx)) : '0;
  end

  always_comb begin
    wr_ok   = wr_en && ({1'b0, wr_x} < 5'(COLS)) && ({1'b0, wr_y} < 5'(ROWS));
    wr_addr = AddrW'(wr_y) * AddrW'(COLS) + AddrW'(wr_x);
  end

  vga_tile_ram #(
    .DEPTH  (Tiles),
    .ADDR_W (AddrW),
    .DATA_W (3)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wr_color),
    .rd_addr (rd_addr),
    .rd_data (tile_color)
  );

  // Cursor only moves at frame start so the box never tears mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_x_q <= '0;
      cur_y_q <= '0;
    end else if (frame_start) begin
      cur_x_q <= xk;
      cur_y_q <= yk;
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BlinkW-1:0] blink_cnt_q;
  logic              phase_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt_q == BlinkW'(BLINK_FRAMES - 1)) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign cursor_phase = phase_q;
`else
  assign cursor_phase = 1'b1;
`endif

  // Stage2: priority colour mux.
  always_comb begin
    rgb_d = BLACK;
    if (attr_q.in_board) begin
      if (attr_q.cursor) begin
        rgb_d = WHITE;
      end else if (attr_q.grid) begin
        rgb_d = BLUE;
      end else begin
        rgb_d = tile_color;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      attr_q <= '0;
      rgb_q  <= BLACK;
    end else begin
      attr_q <= attr_d;
      rgb_q  <= rgb_d;
    end
  end

  assign rgb = rgb_q;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Self-checking bench for vga_tile_renderer: pixel-rule model plus hand-computed probes.
module tb_vga_tile_renderer;

  localparam int HO = 200;
  localparam int VO = 80;
  localparam int T  = 32;
  localparam int NC = 6;
  localparam int NR = 10;
  localparam int HT = 800;
  localparam int BF = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic [3:0] xk;
  logic [3:0] yk;
  logic       wr_en;
  logic [3:0] wr_x;
  logic [3:0] wr_y;
  logic [2:0] wr_color;
  logic [2:0] rgb;
  logic       frame_start;

  always #20 clk = ~clk;

  vga_tile_renderer dut (
    .clk         (clk),
    .rst         (rst),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .xk          (xk),
    .yk          (yk),
    .wr_en       (wr_en),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_color    (wr_color),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  int checks = 0;
  int passed = 0;

  logic [2:0] mram [NC*NR];
  int         mcx = 0;
  int         mcy = 0;
  int         npulses = 0;
  logic [2:0] pipe0 = 3'd0;
  logic [2:0] pipe1 = 3'd0;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0b, expected %0b (h=%0d v=%0d t=%0t)",
                  name, act, exp, hcnt, vcnt, $time);
  endtask

  function automatic bit on_edge(input int o);
    return (o <= 1) || (o >= T - 2);
  endfunction

  // What pixel (px,py) must look like from the board rules alone.
  function automatic logic [2:0] model_pixel(input int px, input int py);
    int tx, ty, ox, oy;
    bit phase;
    if (px >= HT || px < HO || px >= HO + NC * T || py < VO || py >= VO + NR * T) return 3'b000;
    tx = (px - HO) / T;
    ox = (px - HO) % T;
    ty = (py - VO) / T;
    oy = (py - VO) % T;
`ifdef CURSOR_BLINK_EN
    phase = ((npulses / BF) % 2) == 0;
`else
    phase = 1'b1;
`endif
    if (phase && tx == mcx && ty == mcy && (on_edge(ox) || on_edge(oy))) return 3'b111;
    if (ox == 0 || oy == 0) return 3'b001;
    return mram[ty * NC + tx];
  endfunction

  // Compare every cycle: prediction made two cycles ago against the registered output.
  always @(negedge clk) begin
    if (rst) begin
      check("reset_rgb", rgb, 3'b000);
      check("reset_frame_start", {2'b00, frame_start}, 3'b000);
      pipe0 = 3'd0;
      pipe1 = 3'd0;
      mcx = 0;
      mcy = 0;
      npulses = 0;
    end else begin
      check("pipe_rgb", rgb, pipe1);
      check("frame_start", {2'b00, frame_start}, {2'b00, (hcnt == 0 && vcnt == 0)});
      pipe1 = pipe0;
      pipe0 = model_pixel(int'(hcnt) + 2, int'(vcnt));
      if (wr_en && wr_x < NC && wr_y < NR) mram[int'(wr_y) * NC + int'(wr_x)] = wr_color;
      if (hcnt == 0 && vcnt == 0) begin
        mcx = int'(xk);
        mcy = int'(yk);
        npulses++;
      end
    end
  end

  task automatic step(input int h, input int v);
    @(posedge clk);
    #1;
    hcnt = 10'(h);
    vcnt = 10'(v);
  endtask

  task automatic run(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) step(h, v);
  endtask

  task automatic probe(input string name, input int h, input int v, input logic [2:0] exp);
    run(v, h - 2, h);
    @(negedge clk);
    check(name, rgb, exp);
  endtask

  task automatic wr(input int x, input int y, input logic [2:0] c);
    @(posedge clk);
    #1;
    wr_en = 1'b1;
    wr_x = 4'(x);
    wr_y = 4'(y);
    wr_color = c;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic pulse();
    step(0, 0);
    @(negedge clk);
    check("frame_start_pulse", {2'b00, frame_start}, 3'b001);
    step(1, 0);
  endtask

  logic [2:0] blink_exp;

  initial begin
    for (int i = 0; i < NC * NR; i++) mram[i] = 3'd0;
    hcnt = 10'd0;
    vcnt = 10'd500;
    xk = 4'd0;
    yk = 4'd0;
    wr_en = 1'b0;
    wr_x = 4'd0;
    wr_y = 4'd0;
    wr_color = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill the board while the counters sit below it.
    for (int y = 0; y < NR; y++)
      for (int x = 0; x < NC; x++) wr(x, y, 3'((x * 3 + y * 5 + 2) % 8));
    wr(2, 3, 3'b100);
    wr(2, 8, 3'b010);
    wr(0, 0, 3'b110);
    wr(4, 8, 3'b101);
    wr(0, 9, 3'b011);

    // Cursor starts at tile (0,0) after reset.
    probe("cursor_reset_pos", 201, 85, 3'b111);
    probe("tile_2_3_red", 269, 181, 3'b100);
    probe("grid_ox0", 264, 181, 3'b001);
    probe("grid_oy0", 270, 176, 3'b001);
    probe("left_of_board", 199, 181, 3'b000);
    probe("right_inside", 391, 213, 3'b101);
    probe("right_outside", 392, 213, 3'b000);
    probe("bottom_row", 205, 399, 3'b011);
    probe("below_board", 205, 400, 3'b000);
    run(181, 190, 400);
    run(799, 790, 799);

    // Cursor to (2,8) across a frame start.
    xk = 4'd2;
    yk = 4'd8;
    pulse();
    probe("box_corner", 264, 336, 3'b111);
    probe("box_left_ox1", 265, 340, 3'b111);
    probe("box_right_ox30", 294, 340, 3'b111);
    probe("box_right_ox31", 295, 345, 3'b111);
    probe("box_top_oy1", 270, 337, 3'b111);
    probe("box_interior", 270, 345, 3'b010);
    probe("old_cursor_tile", 201, 85, 3'b110);
    run(340, 256, 300);

    // Mid-frame cursor change is held off until the next frame start.
    xk = 4'd4;
    probe("box_not_moved", 265, 340, 3'b111);
    probe("new_tile_plain", 329, 345, 3'b101);
    pulse();
    probe("box_moved", 329, 345, 3'b111);
    probe("old_box_gone", 265, 340, 3'b010);

    // Write colliding with the in-flight read of pixel 270.
    run(345, 260, 267);
    @(posedge clk);
    #1;
    hcnt = 10'd268;
    wr_en = 1'b1;
    wr_x = 4'd2;
    wr_y = 4'd8;
    wr_color = 3'b011;
    @(posedge clk);
    #1;
    hcnt = 10'd269;
    wr_en = 1'b0;
    step(270, 345);
    @(negedge clk);
    check("collision_old", rgb, 3'b010);
    step(271, 345);
    @(negedge clk);
    check("collision_new", rgb, 3'b011);

    // Out-of-range writes must not alias onto real tiles.
    wr(6, 8, 3'b101);
    wr(1, 10, 3'b101);
    probe("wr_x6_ignored", 205, 373, 3'b011);
    probe("wr_y10_ignored", 237 + 5, 373, 3'((1 * 3 + 9 * 5 + 2) % 8));

    // Many frames later the cursor is still drawn unless blinking.
    for (int f = 0; f < 20; f++) pulse();
`ifdef CURSOR_BLINK_EN
    blink_exp = (((npulses / BF) % 2) == 0) ? 3'b111 : 3'b101;
`else
    blink_exp = 3'b111;
`endif
    probe("cursor_after_frames", 329, 345, blink_exp);

    // Reset in the middle of a line, then keep scanning.
    run(340, 250, 260);
    @(posedge clk);
    #1;
    rst = 1'b1;
    hcnt = 10'd261;
    step(262, 340);
    step(263, 340);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hcnt = 10'd264;
    run(340, 265, 300);
    probe("after_reset_cursor_home", 201, 85, 3'b111);
    probe("after_reset_ram_kept", 265, 340, 3'b011);
    run(345, 200, 400);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
